// File: rtl/stream_capture_pkg.sv
// Shared types and constants for the stream capture block: FSM states,
// trigger-mode codes and the registered state bundle.
package stream_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_ORBIT     = 2'd1;
  localparam logic [1:0] TRIG_MATCH     = 2'd2;

  typedef struct packed {
    cap_state_t  state;
    logic [15:0] count;
    logic [16:0] len;
    logic        we;
    logic [31:0] din;
    logic        orbitQ;
  } cap_regs_t;

  localparam cap_regs_t CAP_RESET = '{
    state:  IDLE,
    count:  16'd0,
    len:    17'd0,
    we:     1'b0,
    din:    32'd0,
    orbitQ: 1'b0
  };

  // Zero or an over-long request both mean "fill the whole buffer".
  function automatic logic [16:0] effLen(input logic [15:0] reqLen,
                                         input logic [16:0] depth);
    if ((reqLen == 16'd0) || ({1'b0, reqLen} > depth)) begin
      return depth;
    end
    return {1'b0, reqLen};
  endfunction

endpackage

// File: rtl/stream_capture_bram.sv
// Captures a programmable number of 32-bit stream words into a BRAM port,
// starting on an immediate, orbit-sync edge or masked data-match trigger.
module stream_capture_bram
  import stream_capture_pkg::*;
#(
  parameter int MEM_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  input  logic        fc_orbitSync,
  input  logic        arm,
  input  logic        abort,
  input  logic [1:0]  trig_mode,
  input  logic [31:0] match_value,
  input  logic [31:0] match_mask,
  input  logic [15:0] capture_len,
  output logic        bram_CLK,
  output logic        bram_RST,
  output logic        bram_EN,
  output logic [3:0]  bram_WE,
  output logic [31:0] bram_ADDR,
  output logic [31:0] bram_DIN,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_captured
);

  localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);

  cap_regs_t         r_cur;
  cap_regs_t         w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addrNxt;
  logic              w_accept;
  logic              w_edge;
  logic              w_match;
  logic              w_trigger;
  logic [15:0]       w_countInc;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_cur  <= CAP_RESET;
      r_addr <= '0;
    end else begin
      r_cur  <= w_nxt;
      r_addr <= w_addrNxt;
    end
  end

  assign w_accept   = data_stream_TVALID;
  assign w_edge     = fc_orbitSync & ~r_cur.orbitQ;
  assign w_match    = ((data_stream_TDATA ^ match_value) & match_mask) == 32'd0;
  assign w_countInc = r_cur.count + 16'd1;

  always_comb begin
    w_trigger = 1'b1;
    case (trig_mode)
      TRIG_ORBIT: w_trigger = w_edge;
      TRIG_MATCH: w_trigger = w_match;
      default:    w_trigger = 1'b1;
    endcase
  end

  // Write strobe is a one-cycle pulse; address/data hold between writes.
  always_comb begin
    w_nxt        = r_cur;
    w_nxt.we     = 1'b0;
    w_nxt.orbitQ = fc_orbitSync;
    w_addrNxt    = r_addr;
    if (abort) begin
      w_nxt.state = IDLE;
    end else begin
      case (r_cur.state)
        IDLE, DONE: begin
          if (arm) begin
            w_nxt.len   = effLen(capture_len, DEPTH17);
            w_nxt.count = 16'd0;
            w_nxt.state = ARMED;
          end
        end
        ARMED: begin
          if (w_accept && w_trigger) begin
            w_nxt.we    = 1'b1;
            w_nxt.din   = data_stream_TDATA;
            w_nxt.count = 16'd1;
            w_addrNxt   = '0;
            w_nxt.state = (r_cur.len == 17'd1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_accept) begin
            w_nxt.we    = 1'b1;
            w_nxt.din   = data_stream_TDATA;
            w_nxt.count = w_countInc;
            w_addrNxt   = r_cur.count[ADDR_W-1:0];
            if ({1'b0, w_countInc} == r_cur.len) begin
              w_nxt.state = DONE;
            end
          end
        end
        default: w_nxt.state = IDLE;
      endcase
    end
  end

  assign data_stream_TREADY = 1'b1;
  assign bram_CLK           = clk;
  assign bram_RST           = areset;
  assign bram_EN            = r_cur.we;
  assign bram_WE            = {4{r_cur.we}};
  assign bram_ADDR          = 32'({r_addr, 2'b00});
  assign bram_DIN           = r_cur.din;
  assign busy               = (r_cur.state == ARMED) || (r_cur.state == CAPTURE);
  assign done               = (r_cur.state == DONE);
  assign words_captured     = r_cur.count;

endmodule

// File: tb/tb_stream_capture_bram.sv
// Randomised and directed bench for stream_capture_bram: a capture-window
// reference model feeds a write scoreboard checked by a separate monitor.
module tb_stream_capture_bram;

  localparam int MEM_DEPTH = 2048;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        fcOrbit;
  logic        armIn;
  logic        abortIn;
  logic [1:0]  trigMode;
  logic [31:0] matchValue;
  logic [31:0] matchMask;
  logic [15:0] captureLen;
  logic        bramClk;
  logic        bramRst;
  logic        bramEn;
  logic [3:0]  bramWe;
  logic [31:0] bramAddr;
  logic [31:0] bramDin;
  logic        busyOut;
  logic        doneOut;
  logic [15:0] wordsCaptured;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];

  // Reference model: a capture window described by "waiting for trigger",
  // "words still to take" and "finished" rather than by the DUT's states.
  bit waitTrig;
  int remaining;
  bit finished;
  int mCnt;
  bit mOrbPrev;
  int lastAddr;

  stream_capture_bram #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk                (clk),
    .areset             (areset),
    .data_stream_TDATA  (tdata),
    .data_stream_TVALID (tvalid),
    .data_stream_TREADY (tready),
    .fc_orbitSync       (fcOrbit),
    .arm                (armIn),
    .abort              (abortIn),
    .trig_mode          (trigMode),
    .match_value        (matchValue),
    .match_mask         (matchMask),
    .capture_len        (captureLen),
    .bram_CLK           (bramClk),
    .bram_RST           (bramRst),
    .bram_EN            (bramEn),
    .bram_WE            (bramWe),
    .bram_ADDR          (bramAddr),
    .bram_DIN           (bramDin),
    .busy               (busyOut),
    .done               (doneOut),
    .words_captured     (wordsCaptured)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit edgeSeen;
    bit trigOk;
    int eff;
    edgeSeen = fcOrbit && !mOrbPrev;
    mOrbPrev = fcOrbit;
    if (abortIn) begin
      waitTrig  = 0;
      remaining = 0;
      finished  = 0;
    end else if (!waitTrig && remaining == 0) begin
      if (armIn) begin
        eff = (captureLen == 0 || int'(captureLen) > MEM_DEPTH) ? MEM_DEPTH : int'(captureLen);
        waitTrig  = 1;
        remaining = eff;
        finished  = 0;
        mCnt      = 0;
      end
    end else if (tvalid) begin
      if (waitTrig) begin
        case (trigMode)
          2'd1:    trigOk = edgeSeen;
          2'd2:    trigOk = ((tdata ^ matchValue) & matchMask) == 0;
          default: trigOk = 1;
        endcase
      end else begin
        trigOk = 1;
      end
      if (trigOk) begin
        expQ.push_back('{addr: mCnt, data: tdata});
        mCnt++;
        remaining--;
        waitTrig = 0;
        if (remaining == 0) finished = 1;
      end
    end
  endtask

  initial begin
    waitTrig = 0; remaining = 0; finished = 0; mCnt = 0; mOrbPrev = 0;
    forever begin
      @(posedge clk or posedge areset);
      if (areset) begin
        waitTrig  = 0;
        remaining = 0;
        finished  = 0;
        mCnt      = 0;
        mOrbPrev  = 0;
        expQ.delete();
      end else begin
        modelStep();
      end
    end
  end

  // Monitor: every expected write must appear exactly one cycle after its beat.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!areset) begin
        checkOutput("tready", 32'(tready), 32'd1);
        if (bramEn) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_write", bramAddr, 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("wr_addr", bramAddr, 32'(e.addr) << 2);
            checkOutput("wr_data", bramDin, e.data);
            checkOutput("wr_we", 32'(bramWe), 32'hF);
            lastAddr = int'(bramAddr);
          end
        end else begin
          checkOutput("wr_we_idle", 32'(bramWe), 32'd0);
        end
        checkOutput("missing_write", 32'(expQ.size()), 32'd0);
        checkOutput("busy", 32'(busyOut), 32'(waitTrig || (remaining > 0)));
        checkOutput("done", 32'(doneOut), 32'(finished));
        checkOutput("words_captured", 32'(wordsCaptured), 32'(mCnt));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic orb,
                               input logic a, input logic ab);
    tvalid  = v;
    tdata   = d;
    fcOrbit = orb;
    armIn   = a;
    abortIn = ab;
    @(negedge clk);
  endtask

  task automatic configure(input logic [1:0] mode, input logic [15:0] len,
                           input logic [31:0] mv, input logic [31:0] mm);
    trigMode   = mode;
    captureLen = len;
    matchValue = mv;
    matchMask  = mm;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetPulse();
    #2;
    areset = 1'b1;
    #1;
    checkOutput("rst_en", 32'(bramEn), 32'd0);
    checkOutput("rst_we", 32'(bramWe), 32'd0);
    checkOutput("rst_busy", 32'(busyOut), 32'd0);
    checkOutput("rst_done", 32'(doneOut), 32'd0);
    checkOutput("rst_words", 32'(wordsCaptured), 32'd0);
    checkOutput("rst_addr", bramAddr, 32'd0);
    checkOutput("rst_din", bramDin, 32'd0);
    checkOutput("rst_bram_rst", 32'(bramRst), 32'd1);
    checkOutput("rst_tready", 32'(tready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b0;
    tvalid = 0; tdata = 0; fcOrbit = 0; armIn = 0; abortIn = 0;
    configure(2'd0, 16'd4, 32'd0, 32'd0);
    lastAddr = -1;
    @(negedge clk);
    resetPulse();
    checkOutput("bram_clk", 32'(bramClk), 32'(clk));

    // Immediate trigger, four words from a continuous stream.
    $display("[TB] mode 0, len 4");
    configure(2'd0, 16'd4, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hA0 + i, 1'b0, i == 0, 1'b0);
    idleCycles(2);
    checkOutput("m0_done", 32'(doneOut), 32'd1);
    checkOutput("m0_words", 32'(wordsCaptured), 32'd4);
    checkOutput("m0_last_addr", 32'(lastAddr), 32'd12);

    // Orbit trigger: an edge without a beat is missed.
    $display("[TB] mode 1, len 3");
    configure(2'd1, 16'd3, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h33, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h45, 1'b0, 1'b0, 1'b0);
    checkOutput("m1_wait", 32'(busyOut), 32'd1);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h56, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h57, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h58, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("m1_done", 32'(doneOut), 32'd1);
    checkOutput("m1_words", 32'(wordsCaptured), 32'd3);

    // Masked data match, re-armed directly from DONE.
    $display("[TB] mode 2, len 2");
    configure(2'd2, 16'd2, 32'h1234_0000, 32'hFFFF_0000);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("m2_done", 32'(doneOut), 32'd1);
    checkOutput("m2_last_addr", 32'(lastAddr), 32'd4);

    // Full-buffer lengths: 0 and an oversize request.
    for (int k = 0; k < 2; k++) begin
      $display("[TB] full buffer, len %0d", k == 0 ? 0 : 5000);
      configure(2'd0, k == 0 ? 16'd0 : 16'd5000, 32'd0, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      captureLen = 16'd3;
      for (int i = 0; i < 2200; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      checkOutput("full_done", 32'(doneOut), 32'd1);
      checkOutput("full_words", 32'(wordsCaptured), 32'd2048);
      checkOutput("full_last_addr", 32'(lastAddr), 32'h1FFC);
    end

    // Gapped valid pattern.
    $display("[TB] gapped valid, len 3");
    configure(2'd3, 16'd3, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hB1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hB2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB5, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("gap_words", 32'(wordsCaptured), 32'd3);

    // Abort mid-capture, arm+abort together, then reset mid-capture.
    $display("[TB] abort and reset");
    configure(2'd0, 16'd8, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0, 1'b1);
    idleCycles(1);
    checkOutput("abort_busy", 32'(busyOut), 32'd0);
    checkOutput("abort_done", 32'(doneOut), 32'd0);
    applyStimulus(1'b1, 32'hC3, 1'b0, 1'b1, 1'b1);
    checkOutput("armabort_busy", 32'(busyOut), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hD0 + i, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_en", 32'(bramEn), 32'd1);
    resetPulse();
    idleCycles(1);

    // Randomised segments with live configuration changes.
    $display("[TB] random segments");
    for (int s = 0; s < 12; s++) begin
      configure(2'($urandom_range(0, 3)), 16'($urandom_range(0, 12)), $urandom, 32'h3);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 40) == 0) captureLen = 16'($urandom_range(0, 12));
        applyStimulus($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 12) == 0, $urandom_range(0, 60) == 0);
      end
    end
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_capture_bram.md
Name: stream_capture_bram

Overview:
- Downstream sink for the 32-bit pattern AXI stream driven by the BRAM pattern player.
- Captures a programmable number of stream words into a block-RAM port, starting on a selectable trigger: immediate, orbit-sync edge, or masked data match.
- Software reads the captured buffer back through the BRAM's other port, for loopback checking of link patterns.
- Single clock domain, same clock as the stream.

Parameters:
- MEM_DEPTH, 2048: capture buffer depth in 32-bit words; must be a power of 2.
- ADDR_W, $clog2(MEM_DEPTH): word-address width (derived; not to be overridden).

Ports:
- clk  in  1  stream/BRAM clock
- areset  in  1  asynchronous active-high reset
- data_stream_TDATA  in  32  stream data
- data_stream_TVALID  in  1  stream valid
- data_stream_TREADY  out  1  stream ready
- fc_orbitSync  in  1  orbit-sync fast command (level; rising edge is the event)
- arm  in  1  single-cycle pulse; starts a capture sequence
- abort  in  1  single-cycle pulse; returns to IDLE
- trig_mode  in  2  0 immediate, 1 orbit sync, 2 data match, 3 reserved (behaves as 0)
- match_value  in  32  pattern for mode 2
- match_mask  in  32  bits compared in mode 2
- capture_len  in  16  words to capture; 0 or >MEM_DEPTH means MEM_DEPTH
- bram_CLK  out  1  = clk
- bram_RST  out  1  = areset
- bram_EN  out  1  BRAM enable
- bram_WE  out  4  byte write enables
- bram_ADDR  out  32  byte address = word address << 2, zero-extended
- bram_DIN  out  32  write data
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- words_captured  out  16  words written in current/last capture

Behaviour:
- Reset values: state IDLE; bram_EN, bram_WE, bram_DIN, bram_ADDR, busy, done and words_captured all 0; orbit-edge register 0.
- data_stream_TREADY is constantly 1, including during reset. The upstream player free-runs, so beats outside CAPTURE are discarded.
- Beat accepted = TVALID & TREADY.
- Orbit edge: orbit_q <= fc_orbitSync every cycle; edge = fc_orbitSync & !orbit_q.
- Length latch: eff_len = (capture_len==0 || capture_len>MEM_DEPTH) ? MEM_DEPTH : capture_len. Latched on arm. Later changes to capture_len have no effect until the next arm.
- IDLE: on arm, latch eff_len, clear words_captured, go to ARMED.
- ARMED: trigger depends on trig_mode.
  - Mode 0/3: the first accepted beat triggers.
  - Mode 1: an accepted beat in the same cycle as an orbit edge triggers. An edge without a valid beat is missed; wait for the next edge.
  - Mode 2: an accepted beat with ((TDATA ^ match_value) & match_mask)==0 triggers. mask=0 acts as immediate.
  - The triggering beat is written as word 0. Go to CAPTURE, or straight to DONE if eff_len==1.
- CAPTURE: each accepted beat is written at address words_captured, and words_captured increments. After the write of word eff_len-1, go to DONE. Beats with TVALID=0 write nothing.
- Write pipeline: the write is registered, so bram_EN=1, bram_WE=4'hF, bram_ADDR and bram_DIN are presented the cycle after acceptance. Otherwise bram_EN=0 and bram_WE=0. One-cycle latency from beat to BRAM write.
- words_captured updates in the same cycle as the BRAM write strobe. It holds its final value in DONE and IDLE until the next arm.
- DONE: done=1. arm re-arms: clear counter, latch length, go to ARMED. The final write strobe is issued in the first DONE cycle.
- abort in any state: go to IDLE next cycle; an in-flight write still completes. abort and arm in the same cycle: abort wins.
- arm while ARMED or CAPTURE: ignored.
- Counter/address width: 16-bit word counter; the address uses the low ADDR_W bits. eff_len<=MEM_DEPTH, so the address never wraps within a capture.
- Reset mid-capture: outputs return to reset values immediately (asynchronous); the partial buffer contents are undefined to software.

Decomposition:
- Package stream_capture_pkg holds:
  - typedef enum {IDLE, ARMED, CAPTURE, DONE} cap_state_t;
  - trig_mode constants TRIG_IMMEDIATE=0, TRIG_ORBIT=1, TRIG_MATCH=2.
- No sub-module is needed: the FSM, counter and write register are kept in a single d/q struct style block.

Test Plan:
- Mode 0, capture_len=4, continuous TVALID words 0xA0..0xA9, arm -> writes 0xA?,+1,+2,+3 at byte addrs 0,4,8,12; done after 4th strobe; words_captured=4.
- Mode 1, len=3, orbit rising edge at beat 0x55 -> word0=0x55, next two beats follow; beats before the edge are not written; an edge coinciding with TVALID=0 is skipped.
- Mode 2, value=0x1234_0000, mask=0xFFFF_0000, stream 0x1111_0001, 0x1234_ABCD, 0x9 -> word0=0x1234_ABCD, word1=0x9.
- capture_len=0 and capture_len=5000 with MEM_DEPTH=2048 -> exactly 2048 writes, last at byte addr 0x1FFC, then done.
- Gapped TVALID (1,0,0,1,1), len=3 -> exactly 3 writes at consecutive addresses; no strobes in gap cycles; TREADY=1 throughout.
- Abort at word 2 of 8, then arm+abort in the same cycle, then assert areset mid-capture -> IDLE each time; done=0; busy=0; bram_WE=0 immediately on reset.
